// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned SERIAL_ADDER_WIDTH_DEF = 8;
    localparam int unsigned SERIAL_ADDER_CNT_W     = $clog2(32);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester <-> serial adder handshake and result bus.
// SERIAL_ADDER_SUB_EN adds the 'sub' request qualifier.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/half_adder.sv
// 1-bit half adder.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder: two half adders plus an OR on the carries.
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s0),  .c_o(c0));
    half_adder u_ha1 (.a_i(s0),  .b_i(cin_i), .s_o(s_o), .c_o(c1));

    assign cout_o = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-add cell, LSB first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN: a-b via inverted b and carry-in of 1.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = SERIAL_ADDER_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;
    logic             sub_w;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = bus.sub;
`else
    assign sub_w = 1'b0;
`endif

    serial_fa_cell u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, shift and result logic
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = sub_w ? ~bus.b : bus.b;
                    carry_d = sub_w;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                // Publish only on the last bit so sum/cout hold the old result during RUN
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed, table-driven bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic [W-1:0] es, input logic ec);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // Called in the cycle after the accepting edge; returns edges until done
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bc++;
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat, bc;
        drive_start(v.a, v.b, v.sub);
        step();
        bus.start = 1'b0;
        bus.a = ~v.a;
        bus.b = ~v.b;
        wait_done(lat, bc);
        check({name, " latency"}, 32'(lat), 32'(W));
        check({name, " busy cycles"}, 32'(bc), 32'(W));
        check({name, " busy at done"}, 32'(bus.busy), 32'd0);
        check({name, " sum"}, 32'(bus.sum), 32'(v.es));
        check({name, " cout"}, 32'(bus.cout), 32'(v.ec));
        step();
        check({name, " done pulse width"}, 32'(bus.done), 32'd0);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int lat, bc, cnt;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif

        vecs.push_back(mk(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0));
        vecs.push_back(mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0));
        vecs.push_back(mk(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1));
        vecs.push_back(mk(8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'h12, 8'h34, 1'b0, 8'h46, 1'b0));
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back(mk(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0));
        vecs.push_back(mk(8'h07, 8'h05, 1'b1, 8'h02, 1'b1));
        vecs.push_back(mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b1));
`endif

        // Reset with a coincident start request: reset must win
        drive_start(8'hFF, 8'hFF, 1'b0);
        step();
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        count_done(20, cnt);
        check("idle done count", 32'(cnt), 32'd0);
        check("idle busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Result holds after done
        run_op("hold", mk(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0));
        for (int i = 0; i < 5; i++) step();
        check("hold sum", 32'(bus.sum), 32'hFF);
        check("hold cout", 32'(bus.cout), 32'd0);

        // Back-to-back start accepted in the DONE cycle; old result held during RUN
        drive_start(8'hFF, 8'h01, 1'b0);
        step();
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("b2b first latency", 32'(lat), 32'(W));
        check("b2b first sum", 32'(bus.sum), 32'h00);
        check("b2b first cout", 32'(bus.cout), 32'd1);
        drive_start(8'hA5, 8'h5A, 1'b0);
        step();
        bus.start = 1'b0;
        check("b2b accepted busy", 32'(bus.busy), 32'd1);
        check("b2b sum held in run", 32'(bus.sum), 32'h00);
        check("b2b cout held in run", 32'(bus.cout), 32'd1);
        wait_done(lat, bc);
        check("b2b second latency", 32'(lat), 32'(W));
        check("b2b second sum", 32'(bus.sum), 32'hFF);
        check("b2b second cout", 32'(bus.cout), 32'd0);
        step();

        // Start while busy is ignored
        drive_start(8'h03, 8'h04, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        step();
        drive_start(8'hF0, 8'h0F, 1'b0);
        step();
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("busy-start latency", 32'(lat), 32'(W - 3));
        check("busy-start sum", 32'(bus.sum), 32'h07);
        check("busy-start cout", 32'(bus.cout), 32'd0);
        count_done(20, cnt);
        check("busy-start extra done", 32'(cnt), 32'd0);
        check("busy-start idle busy", 32'(bus.busy), 32'd0);

        // Reset mid-operation discards the partial result
        drive_start(8'h7F, 8'h01, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst sum", 32'(bus.sum), 32'h00);
        check("midrst cout", 32'(bus.cout), 32'd0);
        count_done(15, cnt);
        check("midrst done count", 32'(cnt), 32'd0);
        run_op("after rst", mk(8'h10, 8'h20, 1'b0, 8'h30, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder controller. It time-multiplexes a single 1-bit full-add cell, built from two half_adder instances, over WIDTH cycles, LSB first.
- Takes a start strobe with two WIDTH-bit operands.
- Sequences one bit per clock and reports sum/cout with a done pulse.
- Sits between a requester and the shared 1-bit adder datapath; it is the area-minimal alternative to a ripple-carry chain.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled on rising edge of clk
a  input  WIDTH  operand A; sampled only when start is accepted
b  input  WIDTH  operand B; sampled only when start is accepted
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result; held stable from done until next accepted start
cout  output  1  carry out of MSB; held with sum

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand shift registers=0.
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per cycle.
  - DONE: one cycle; done=1.
- IDLE or DONE with start=1:
  - latch a, b into shift registers; carry<=0; counter<=0; state<=RUN.
  - busy=1 from the next cycle.
- RUN, each edge:
  - cell inputs: a_sh[0], b_sh[0], carry.
  - s = a^b^carry; c = (a&b) | ((a^b)&carry), via two half_adder plus OR.
  - shift a_sh, b_sh right by one; shift s into sum_sh MSB; carry<=c; counter++.
  - when counter==WIDTH-1 on this edge: state<=DONE; sum<=final sum_sh; cout<=c.
- DONE: done=1, busy=0 for exactly one cycle. Next state is RUN if start=1, else IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle following edge WIDTH. Back-to-back throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; no queueing and no error. Operands are not re-sampled.
- a/b changing during RUN has no effect.
- rst asserted at any time, including mid-RUN: next edge returns to reset values. The partial result is discarded and no done is issued.
- rst and start in the same cycle: rst wins.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the (WIDTH+1)th bit.
- sum/cout are not updated during RUN; they keep the previous result until the new done.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start.
  - sub=1: the latched b is inverted and the initial carry is set to 1, computing a-b modulo 2^WIDTH.
  - cout=1 means no borrow (a>=b).
  - sub=0 behaves exactly as the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package serial_adder_pkg:
  - state typedef enum {IDLE, RUN, DONE} as a 2-bit logic.
  - default-width constant SERIAL_ADDER_WIDTH_DEF=8.
  - counter width constant $clog2(32).
- Sub-module serial_fa_cell: a combinational 1-bit full adder composed of two existing half_adder instances plus an OR for carry. It is instantiated once in serial_adder_ctrl.
- Controller FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
WIDTH=8 unless noted.
- Reset then idle: rst high for 2 cycles. Expect busy=0, done=0, sum=0x00, cout=0, with no done over 20 idle cycles.
- Basic add: start with a=0xA5, b=0x5A. Expect busy=1 for 8 cycles, then done=1 for exactly 1 cycle, sum=0xFF, cout=0. sum must still be 0xFF 5 cycles later.
- Carry chain/overflow: a=0xFF, b=0x01 gives sum=0x00, cout=1. a=0x80, b=0x80 gives sum=0x00, cout=1. A back-to-back start in the DONE cycle must be accepted.
- Start during busy: start a=0x03, b=0x04, then pulse start with a=0xF0, b=0x0F at cycle 3. Expect a single done at the original time with sum=0x07, cout=0.
- Reset mid-op: start a=0x7F, b=0x01, assert rst at cycle 4. Expect no done, sum=0x00, busy=0. A following start a=0x10, b=0x20 gives sum=0x30.
- SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1 gives sum=0xFE, cout=0. a=0x07, b=0x05, sub=1 gives sum=0x02, cout=1.
